// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multicycle processor control unit.
//   state_t        : FSM state encoding (FETCH=0 ... HALT=11), also exported
//                    on the debug state port
//   OP_*           : opcode values of the instruction set
//   SRCA_* / SRCB_*: ALU operand select encodings
//   ALU_*          : ALU operation encodings
//   decodeTarget() : state reached from DECODE for a given opcode
//   aluOpFor()     : ALU operation for an R-type opcode
// -----------------------------------------------------------------------------
package control_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      EXEC_R    = 4'd2,
      EXEC_I    = 4'd3,
      MEM_ADDR  = 4'd4,
      MEM_READ  = 4'd5,
      MEM_WB    = 4'd6,
      MEM_WRITE = 4'd7,
      REG_WB    = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10,
      HALT      = 4'd11
   } state_t;

   localparam int unsigned OP_ADD  = 32'd0;
   localparam int unsigned OP_SUB  = 32'd1;
   localparam int unsigned OP_AND  = 32'd2;
   localparam int unsigned OP_OR   = 32'd3;
   localparam int unsigned OP_ADDI = 32'd4;
   localparam int unsigned OP_LW   = 32'd5;
   localparam int unsigned OP_SW   = 32'd6;
   localparam int unsigned OP_BEQ  = 32'd7;
   localparam int unsigned OP_BLT  = 32'd8;
   localparam int unsigned OP_JMP  = 32'd9;
   localparam int unsigned OP_HALT = 32'd15;

   localparam logic [1:0] SRCA_PC  = 2'd0;
   localparam logic [1:0] SRCA_TWO = 2'd1;
   localparam logic [1:0] SRCA_REG = 2'd2;

   localparam logic [1:0] SRCB_REG = 2'd0;
   localparam logic [1:0] SRCB_TWO = 2'd1;
   localparam logic [1:0] SRCB_IMM = 2'd2;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   // Opcode dispatch out of DECODE; anything unrecognised ends in HALT
   function automatic state_t decodeTarget(input logic [31:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: decodeTarget = EXEC_R;
         OP_ADDI:                       decodeTarget = EXEC_I;
         OP_LW, OP_SW:                  decodeTarget = MEM_ADDR;
         OP_BEQ, OP_BLT:                decodeTarget = BRANCH;
         OP_JMP:                        decodeTarget = JUMP;
         default:                       decodeTarget = HALT;
      endcase
   endfunction

   function automatic logic [2:0] aluOpFor(input logic [31:0] op);
      case (op)
         OP_SUB:  aluOpFor = ALU_SUB;
         OP_AND:  aluOpFor = ALU_AND;
         OP_OR:   aluOpFor = ALU_OR;
         default: aluOpFor = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_decode.sv
// -----------------------------------------------------------------------------
// control_decode
// Combinational decode of the current FSM state into datapath selects and
// strobes.
//   state_i, opcode_i             : current state and instruction opcode
//   zero_i, negative_i            : ALU flags, used for the branch decision
//   memReady_i                    : memory handshake, qualifies fetch writes
//   illegalFlag_i                 : HALT was reached through a bad opcode
//   active_i                      : low while reset is asserted
//   aluSrcA_o .. pcSrc_o          : datapath selects
//   pcWrite_o .. illegal_o        : strobes
// -----------------------------------------------------------------------------
module control_decode
   import control_pkg::*;
#(
   parameter int OPW = 4
)
(
   input  state_t         state_i,
   input  logic [OPW-1:0] opcode_i,
   input  logic           zero_i,
   input  logic           negative_i,
   input  logic           memReady_i,
   input  logic           illegalFlag_i,
   input  logic           active_i,
   output logic [1:0]     aluSrcA_o,
   output logic [1:0]     aluSrcB_o,
   output logic [2:0]     aluOp_o,
   output logic           pcSrc_o,
   output logic           pcWrite_o,
   output logic           irWrite_o,
   output logic           memRead_o,
   output logic           memWrite_o,
   output logic           regWrite_o,
   output logic           memtoReg_o,
   output logic           illegal_o
);

   logic [31:0] opVal;

   assign opVal = 32'(opcode_i);

   // Everything defaults to idle so each state only names what it drives.
   // The write strobes are additionally forced low while reset is held so
   // nothing can be written between reset assertion and the first fetch
   // (FETCH would otherwise follow mem_ready straight into PC/IR writes).
   always_comb begin
      aluSrcA_o  = SRCA_PC;
      aluSrcB_o  = SRCB_REG;
      aluOp_o    = ALU_ADD;
      pcSrc_o    = 1'b0;
      pcWrite_o  = 1'b0;
      irWrite_o  = 1'b0;
      memRead_o  = 1'b0;
      memWrite_o = 1'b0;
      regWrite_o = 1'b0;
      memtoReg_o = 1'b0;
      illegal_o  = 1'b0;
      case (state_i)
         FETCH: begin
            memRead_o = 1'b1;
            aluSrcB_o = SRCB_TWO;
            irWrite_o = memReady_i;
            pcWrite_o = memReady_i;
         end
         DECODE: begin
            aluSrcB_o = SRCB_IMM;
         end
         EXEC_R: begin
            aluSrcA_o = SRCA_REG;
            aluSrcB_o = SRCB_REG;
            aluOp_o   = aluOpFor(opVal);
         end
         EXEC_I, MEM_ADDR: begin
            aluSrcA_o = SRCA_REG;
            aluSrcB_o = SRCB_IMM;
         end
         MEM_READ: begin
            memRead_o = 1'b1;
         end
         MEM_WRITE: begin
            memWrite_o = 1'b1;
         end
         MEM_WB: begin
            regWrite_o = 1'b1;
            memtoReg_o = 1'b1;
         end
         REG_WB: begin
            regWrite_o = 1'b1;
         end
         BRANCH: begin
            aluSrcA_o = SRCA_REG;
            aluSrcB_o = SRCB_REG;
            aluOp_o   = ALU_SUB;
            pcSrc_o   = 1'b1;
            pcWrite_o = (opVal == OP_BLT) ? negative_i : zero_i;
         end
         JUMP: begin
            pcSrc_o   = 1'b1;
            pcWrite_o = 1'b1;
         end
         HALT: begin
            illegal_o = illegalFlag_i;
         end
         default: begin
         end
      endcase
      if (!active_i) begin
         pcWrite_o  = 1'b0;
         irWrite_o  = 1'b0;
         memWrite_o = 1'b0;
         regWrite_o = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Control FSM of a multicycle processor: holds the state register, the
// retired-instruction counter and the illegal-opcode flag; output decode
// lives in control_decode.
//   clk, reset_n                     : clock, async active-low reset
//   input_opcode                     : opcode field of the instruction register
//   input_Zero, input_negative       : ALU flags
//   input_mem_ready                  : memory handshake
//   output_ALUSrcA .. output_PCSrc   : datapath selects
//   output_PCWrite .. output_illegal : strobes
//   output_state, output_instret     : debug state and retired count
// -----------------------------------------------------------------------------
module multicycle_control
   import control_pkg::*;
#(
   parameter int OPW  = 4,
   parameter int CNTW = 16
)
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic [OPW-1:0]  input_opcode,
   input  logic            input_Zero,
   input  logic            input_negative,
   input  logic            input_mem_ready,
   output logic [1:0]      output_ALUSrcA,
   output logic [1:0]      output_ALUSrcB,
   output logic [2:0]      output_ALUOp,
   output logic            output_PCSrc,
   output logic            output_PCWrite,
   output logic            output_IRWrite,
   output logic            output_MemRead,
   output logic            output_MemWrite,
   output logic            output_RegWrite,
   output logic            output_MemtoReg,
   output logic            output_illegal,
   output logic [3:0]      output_state,
   output logic [CNTW-1:0] output_instret
);

   state_t          state_q;
   state_t          state_d;
   logic [CNTW-1:0] instret_q;
   logic            illegal_q;
   logic [31:0]     opVal;

   assign opVal = 32'(input_opcode);

   // Next-state selection. Memory states wait on mem_ready, every completed
   // instruction returns to FETCH, and HALT is only left through reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:             if (input_mem_ready) state_d = DECODE;
         DECODE:            state_d = decodeTarget(opVal);
         EXEC_R, EXEC_I:    state_d = REG_WB;
         MEM_ADDR:          state_d = (opVal == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ:          if (input_mem_ready) state_d = MEM_WB;
         MEM_WRITE:         if (input_mem_ready) state_d = FETCH;
         REG_WB, MEM_WB,
         BRANCH, JUMP:      state_d = FETCH;
         HALT:              state_d = HALT;
         default:           state_d = FETCH;
      endcase
   end

   // State register plus the bookkeeping tied to its transitions: an
   // instruction retires whenever we come back into FETCH from elsewhere,
   // and the illegal flag remembers a HALT caused by an unknown opcode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FETCH;
         instret_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q != FETCH && state_d == FETCH) begin
            instret_q <= instret_q + CNTW'(1);
         end
         if (state_q == DECODE && state_d == HALT && opVal != OP_HALT) begin
            illegal_q <= 1'b1;
         end
      end
   end

   assign output_state   = state_q;
   assign output_instret = instret_q;

   control_decode #(
      .OPW (OPW)
   ) uDecode (
      .state_i       (state_q),
      .opcode_i      (input_opcode),
      .zero_i        (input_Zero),
      .negative_i    (input_negative),
      .memReady_i    (input_mem_ready),
      .illegalFlag_i (illegal_q),
      .active_i      (reset_n),
      .aluSrcA_o     (output_ALUSrcA),
      .aluSrcB_o     (output_ALUSrcB),
      .aluOp_o       (output_ALUOp),
      .pcSrc_o       (output_PCSrc),
      .pcWrite_o     (output_PCWrite),
      .irWrite_o     (output_IRWrite),
      .memRead_o     (output_MemRead),
      .memWrite_o    (output_MemWrite),
      .regWrite_o    (output_RegWrite),
      .memtoReg_o    (output_MemtoReg),
      .illegal_o     (output_illegal)
   );

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPW, default 4, opcode width in bits.
REQ-002 SHALL have parameter CNTW, default 16, retired-instruction counter width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port input_opcode, input, OPW, opcode field of the instruction register.
REQ-006 SHALL have ports input_Zero and input_negative, input, 1 each, ALU flags from the calculations datapath.
REQ-007 SHALL have port input_mem_ready, input, 1, memory-ready handshake.
REQ-008 SHALL have ports output_ALUSrcA (2), output_ALUSrcB (2), output_ALUOp (3), output_PCSrc (1), all output, datapath selects.
REQ-009 SHALL have ports output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite, output_RegWrite, output_MemtoReg, output_illegal, all output, 1 each, strobes.
REQ-010 SHALL have ports output_state (4) and output_instret (CNTW), both output, debug visibility.

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, REG_WB, BRANCH, JUMP, HALT.
REQ-012 SHALL decode opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 BLT, 9 JMP, F HALT; all others illegal.
REQ-013 SHALL encode ALUSrcA 0=PC, 1=const 2, 2=A; ALUSrcB 0=B, 1=const 2, 2=imm; ALUOp 0 add, 1 sub, 2 and, 3 or.
REQ-014 SHALL, in FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSrc=0; IRWrite=PCWrite=1 only in the cycle input_mem_ready=1, then go to DECODE; otherwise hold FETCH.
REQ-015 SHALL, in DECODE: ALUSrcA=0, ALUSrcB=2, ALUOp=add (branch target into ALUOut); branch on opcode: R-type->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ/BLT->BRANCH, JMP->JUMP, HALT or illegal->HALT.
REQ-016 SHALL, in EXEC_R: ALUSrcA=2, ALUSrcB=0, ALUOp per opcode; EXEC_I: ALUSrcA=2, ALUSrcB=2, add; both -> REG_WB.
REQ-017 SHALL, in REG_WB: RegWrite=1, MemtoReg=0, -> FETCH.
REQ-018 SHALL, in MEM_ADDR: ALUSrcA=2, ALUSrcB=2, add; LW->MEM_READ, SW->MEM_WRITE.
REQ-019 SHALL hold MEM_READ (MemRead=1) and MEM_WRITE (MemWrite=1) until input_mem_ready=1; MEM_READ->MEM_WB, MEM_WRITE->FETCH.
REQ-020 SHALL, in MEM_WB: RegWrite=1, MemtoReg=1, -> FETCH.
REQ-021 SHALL, in BRANCH: ALUSrcA=2, ALUSrcB=0, sub, PCSrc=1, PCWrite combinationally = input_Zero (BEQ) or input_negative (BLT) in that cycle; -> FETCH.
REQ-022 SHALL, in JUMP: PCSrc=1, PCWrite=1, -> FETCH.
REQ-023 SHALL stay in HALT indefinitely with all strobes 0; output_illegal=1 when entered via illegal opcode, 0 via opcode F; exit only by reset.
REQ-024 SHALL deassert every strobe in states not listing it; selects default 0.
REQ-025 SHALL increment output_instret on each transition into FETCH from a non-FETCH state, wrapping at 2^CNTW-1 -> 0.
REQ-026 SHALL drive output_state with the current state encoding (FETCH=0 ... HALT=11, in REQ-011 order).
REQ-027 SHALL yield cycle counts with zero wait states: R/ADDI 4, LW 5, SW 4, BEQ/BLT 3, JMP 3.

Reset
REQ-028 SHALL, on reset_n=0, immediately enter FETCH, clear output_instret and the illegal flag, independent of clk.
REQ-029 SHALL, on reset mid-instruction (any state, including memory wait), abandon it with no write strobe asserted after reset assertion.
REQ-030 SHALL begin fetching on the first rising clk edge after reset_n deasserts.

Structure
REQ-031 SHALL place state encodings, opcode constants and ALUOp/ALUSrc encodings in shared package control_pkg.
REQ-032 SHALL split combinational output decode into sub-module control_decode; state register and counter remain in multicycle_control.

Verification
REQ-033 ADD (op 0), mem_ready=1 -> states 0,1,2,8,0; RegWrite one cycle; instret 0->1.
REQ-034 LW (op 5), mem_ready low 3 cycles in MEM_READ -> MemRead held 4 cycles, then MEM_WB with MemtoReg=1; total 8 cycles.
REQ-035 BEQ with Zero=1 -> PCWrite=1, PCSrc=1 in BRANCH; repeat with Zero=0 -> PCWrite=0.
REQ-036 Opcode A -> HALT, output_illegal=1, strobes 0 for 20 cycles; opcode F -> HALT, illegal=0.
REQ-037 reset_n pulsed low mid MEM_WRITE -> state=0 asynchronously, MemWrite=0, instret=0.
REQ-038 instret preset by 65535 ADDIs -> next retirement wraps to 0.
